prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_pkg.sv | 19 +
 rtl/prbs_predictor.sv | 42 ++++
 rtl/prbs_checker.sv | 142 ++++++++++++++
 tb/tb_prbs_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-26 self-synchronising checker:
// default length, recurrence tap positions and the lock-state encoding.
package prbs_pkg;

   localparam int PRBS_N = 26;

   // h[k] is the valid bit received k+1 valid bits earlier
   localparam int TAP_A = 19;
   localparam int TAP_B = 23;
   localparam int TAP_C = 24;
   localparam int TAP_D = 25;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRAIN  = 2'd1,
      LOCKED = 2'd2
   } prbs_state_e;

endpackage

// File: rtl/prbs_predictor.sv
// History shift register of received valid bits; produces the predicted
// next bit of x^26+x^6+x^2+x+1 and an all-zero history flag.
module prbs_predictor
   import prbs_pkg::*;
#(
   parameter int N = PRBS_N
)
(
   input  logic clk,
   input  logic r,
   input  logic shift_en,
   input  logic din,
   output logic predicted,
   output logic hist_zero
);

   logic [N-1:0] hist_q;
   logic [N-1:0] hist_d;

   // Newest bit enters at index 0 so hist_q[k] is h[k]
   always_comb begin
      hist_d = hist_q;
      if (shift_en) begin
         hist_d = {hist_q[N-2:0], din};
      end else begin
         hist_d = hist_q;
      end
   end

   // History register
   always_ff @(posedge clk) begin
      if (r) begin
         hist_q <= {N{1'b0}};
      end else begin
         hist_q <= hist_d;
      end
   end

   assign predicted = hist_q[TAP_A] ^ hist_q[TAP_B] ^ hist_q[TAP_C] ^ hist_q[TAP_D];
   assign hist_zero = (hist_q == {N{1'b0}});

endmodule

// File: rtl/prbs_checker.sv
// PRBS-26 receive checker: acquires lock on a clean stream, then flags
// and counts mismatched bits, dropping lock after a run of mismatches.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int N        = PRBS_N,
   parameter int LOCK_CNT = 32,
   parameter int LOSS_CNT = 8
)
(
   input  logic        clk,
   input  logic        r,
   input  logic        din,
   input  logic        din_valid,
   input  logic        clr_cnt,
   output logic        locked,
   output logic        err,
   output logic [15:0] err_count
);

   localparam int FILL_W  = $clog2(N + 1);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W  = $clog2(LOSS_CNT + 1);

   prbs_state_e        state_q, state_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic [15:0]        err_count_q, err_count_d;
   logic               locked_q, locked_d;
   logic               err_q, err_d;
   logic               predicted;
   logic               hist_zero;
   logic               mismatch;

   prbs_predictor #(.N(N)) u_predictor (
      .clk       (clk),
      .r         (r),
      .shift_en  (din_valid),
      .din       (din),
      .predicted (predicted),
      .hist_zero (hist_zero)
   );

   assign mismatch = din ^ predicted;

   // Lock FSM and its run counters; idle cycles only drop err
   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      match_d = match_q;
      miss_d  = miss_q;
      err_d   = 1'b0;
      if (din_valid) begin
         case (state_q)
            SEARCH: begin
               if (fill_q == FILL_W'(N - 1)) begin
                  state_d = TRAIN;
                  fill_d  = {FILL_W{1'b0}};
                  match_d = {MATCH_W{1'b0}};
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
            TRAIN: begin
               if (hist_zero || mismatch) begin
                  match_d = {MATCH_W{1'b0}};
               end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                  state_d = LOCKED;
                  match_d = {MATCH_W{1'b0}};
                  miss_d  = {MISS_W{1'b0}};
               end else begin
                  match_d = match_q + 1'b1;
               end
            end
            LOCKED: begin
               if (mismatch) begin
                  err_d = 1'b1;
                  if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                     state_d = SEARCH;
                     fill_d  = {FILL_W{1'b0}};
                     match_d = {MATCH_W{1'b0}};
                     miss_d  = {MISS_W{1'b0}};
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end else begin
                  miss_d = {MISS_W{1'b0}};
               end
            end
            default: begin
               state_d = SEARCH;
               fill_d  = {FILL_W{1'b0}};
               match_d = {MATCH_W{1'b0}};
               miss_d  = {MISS_W{1'b0}};
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Saturating error counter; a clear beats a coincident increment
   always_comb begin
      err_count_d = err_count_q;
      if (clr_cnt) begin
         err_count_d = 16'h0000;
      end else if (err_d && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'h0001;
      end else begin
         err_count_d = err_count_q;
      end
   end

   assign locked_d = (state_d == LOCKED);

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (r) begin
         state_q     <= SEARCH;
         fill_q      <= {FILL_W{1'b0}};
         match_q     <= {MATCH_W{1'b0}};
         miss_q      <= {MISS_W{1'b0}};
         err_count_q <= 16'h0000;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         miss_q      <= miss_d;
         err_count_q <= err_count_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
      end
   end

   assign locked    = locked_q;
   assign err       = err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed lock/error/loss scenarios
// plus randomized traffic against a bit-history reference model.
module tb_prbs_checker;

   localparam int N        = 26;
   localparam int LOCK_CNT = 32;
   localparam int LOSS_CNT = 8;

   localparam int M_SEARCH = 0;
   localparam int M_TRAIN  = 1;
   localparam int M_LOCKED = 2;

   logic        clk = 1'b0;
   logic        r = 1'b1;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic        clr_cnt = 1'b0;
   logic        locked;
   logic        err;
   logic [15:0] err_count;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   prbs_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
      .clk       (clk),
      .r         (r),
      .din       (din),
      .din_valid (din_valid),
      .clr_cnt   (clr_cnt),
      .locked    (locked),
      .err       (err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Reference generator: seed bits emerge MSB first, then the recurrence
   bit          gen_s[$];
   int          gen_n;
   logic [25:0] gen_seed;

   function automatic void gen_restart(input logic [25:0] seed);
      gen_s.delete();
      gen_n    = 0;
      gen_seed = seed;
   endfunction

   function automatic bit gen_next();
      bit b;
      int sz;
      sz = gen_s.size();
      if (gen_n < 26) b = gen_seed[25 - gen_n];
      else            b = gen_s[sz-20] ^ gen_s[sz-24] ^ gen_s[sz-25] ^ gen_s[sz-26];
      gen_s.push_back(b);
      if (gen_s.size() > 32) void'(gen_s.pop_front());
      gen_n++;
      return b;
   endfunction

   // Reference model: explicit list of received bits plus lock bookkeeping
   bit m_hist[$];
   int m_mode, m_fill, m_match, m_miss;
   int exp_locked = 0, exp_err = 0, exp_cnt = 0;

   function automatic bit hist_bit(input int k);
      int n;
      n = m_hist.size();
      return (k < n) ? m_hist[n-1-k] : 1'b0;
   endfunction

   function automatic void model_step(input bit rr, input bit v, input bit d, input bit c);
      bit pred, hz;
      if (rr) begin
         m_hist.delete();
         m_mode = M_SEARCH; m_fill = 0; m_match = 0; m_miss = 0;
         exp_locked = 0; exp_err = 0; exp_cnt = 0;
         return;
      end
      exp_err = 0;
      if (v) begin
         pred = hist_bit(19) ^ hist_bit(23) ^ hist_bit(24) ^ hist_bit(25);
         hz = 1'b1;
         for (int k = 0; k < N; k++) if (hist_bit(k)) hz = 1'b0;
         if (m_mode == M_SEARCH) begin
            m_fill++;
            if (m_fill == N) begin m_mode = M_TRAIN; m_match = 0; end
         end else if (m_mode == M_TRAIN) begin
            if (hz || d != pred) m_match = 0;
            else m_match++;
            if (m_match == LOCK_CNT) begin m_mode = M_LOCKED; m_miss = 0; end
         end else begin
            if (d != pred) begin
               exp_err = 1;
               if (exp_cnt < 65535) exp_cnt++;
               m_miss++;
               if (m_miss == LOSS_CNT) begin
                  m_mode = M_SEARCH; m_fill = 0; m_match = 0; m_miss = 0;
               end
            end else begin
               m_miss = 0;
            end
         end
         m_hist.push_back(d);
         if (m_hist.size() > 64) void'(m_hist.pop_front());
      end
      if (c) exp_cnt = 0;
      exp_locked = (m_mode == M_LOCKED) ? 1 : 0;
   endfunction

   task automatic step(input bit rr, input bit v, input bit d, input bit c);
      r = rr; din_valid = v; din = d; clr_cnt = c;
      @(posedge clk);
      model_step(rr, v, d, c);
      #1;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      gen_restart(26'd1);
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_locked", locked, exp_locked);
         chk("cyc_err", err, exp_err);
         chk("cyc_err_count", err_count, exp_cnt);
      end
   end

   initial begin
      bit          b, v, rr, c;
      logic [51:0] first52;
      int          cnt, cnt2, vb, burst, seen;

      // Reset state
      do_reset();
      check_en = 1'b1;
      chk("rst_locked", locked, 0);
      chk("rst_err", err, 0);
      chk("rst_err_count", err_count, 0);

      // Clean stream, seed 1: lock exactly after valid bit 58
      cnt = 0;
      first52 = '0;
      for (int i = 1; i <= 500; i++) begin
         b = gen_next();
         if (i <= 52) first52[i-1] = b;
         step(1'b0, 1'b1, b, 1'b0);
         if (i < 58 && locked) cnt++;
         if (i == 57) chk("lock_bit57", locked, 0);
         if (i == 58) chk("lock_bit58", locked, 1);
      end
      chk("gen_first52", first52, 52'hE200002000000);
      chk("prelock_high", cnt, 0);
      chk("clean_cnt500", err_count, 0);

      // Single flipped bit while locked: five pulses, lock kept
      do_reset();
      cnt = 0; cnt2 = 0;
      for (int i = 1; i <= 160; i++) begin
         b = gen_next();
         if (i == 100) b = ~b;
         step(1'b0, 1'b1, b, 1'b0);
         if (err) cnt++;
         if (i >= 58 && !locked) cnt2++;
         if (i == 126) chk("flip_tap26_err", err, 1);
      end
      chk("flip_pulses", cnt, 5);
      chk("flip_err_count", err_count, 5);
      chk("flip_unlock", cnt2, 0);

      // All-zero stream never locks
      do_reset();
      cnt = 0;
      for (int i = 1; i <= 200; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         if (locked) cnt++;
      end
      chk("zero_locked", cnt, 0);
      chk("zero_err_count", err_count, 0);

      // Eight inverted bits drop lock; clean stream relocks after 58
      do_reset();
      for (int i = 1; i <= 80; i++) step(1'b0, 1'b1, gen_next(), 1'b0);
      chk("loss_prelocked", locked, 1);
      for (int i = 1; i <= LOSS_CNT; i++) begin
         step(1'b0, 1'b1, ~gen_next(), 1'b0);
         if (i == LOSS_CNT - 1) chk("loss_bit7", locked, 1);
         if (i == LOSS_CNT)     chk("loss_bit8", locked, 0);
      end
      for (int i = 1; i <= 58; i++) begin
         step(1'b0, 1'b1, gen_next(), 1'b0);
         if (i == 57) chk("relock_57", locked, 0);
         if (i == 58) chk("relock_58", locked, 1);
      end

      // din_valid toggling: lock after 58 valid bits, no err on idle cycles
      do_reset();
      vb = 0; cnt = 0;
      for (int cyc = 1; cyc <= 130; cyc++) begin
         v = cyc[0];
         if (v) begin b = gen_next(); vb++; end
         else   b = 1'($urandom_range(0, 1));
         step(1'b0, v, b, 1'b0);
         if (!v && err) cnt++;
         if (cyc == 114) chk("toggle_cyc114", locked, 0);
         if (cyc == 115) chk("toggle_cyc115", locked, 1);
      end
      chk("toggle_idle_err", cnt, 0);
      chk("toggle_vb", vb, 65);

      // clr_cnt beats a coincident error; reset while locked clears outputs
      do_reset();
      for (int i = 1; i <= 60; i++) step(1'b0, 1'b1, gen_next(), 1'b0);
      step(1'b0, 1'b1, ~gen_next(), 1'b1);
      chk("clr_err", err, 1);
      chk("clr_err_count", err_count, 0);
      for (int i = 62; i <= 81; i++) step(1'b0, 1'b1, gen_next(), 1'b0);
      chk("clr_then_tap", err_count, 1);
      for (int i = 82; i <= 84; i++) step(1'b0, 1'b1, gen_next(), 1'b0);
      step(1'b1, 1'b1, gen_next(), 1'b0);
      chk("rst_mid_locked", locked, 0);
      chk("rst_mid_err", err, 0);
      chk("rst_mid_count", err_count, 0);
      for (int i = 1; i <= 58; i++) begin
         step(1'b0, 1'b1, gen_next(), 1'b0);
         if (i == 57) chk("rst_relock_57", locked, 0);
         if (i == 58) chk("rst_relock_58", locked, 1);
      end

      // Randomized traffic against the model
      gen_restart(26'($urandom()) | 26'd1);
      burst = 0; seen = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         v  = ($urandom_range(0, 9) < 7);
         rr = ($urandom_range(0, 1999) == 0);
         c  = ($urandom_range(0, 199) == 0);
         if (v) begin
            b = gen_next();
            if (burst > 0) begin b = ~b; burst--; end
            else if ($urandom_range(0, 1499) == 0) burst = 10;
            else if ($urandom_range(0, 199) == 0) b = ~b;
         end else begin
            b = 1'($urandom_range(0, 1));
         end
         step(rr, v, b, c);
         if (locked) seen++;
      end
      chk("rand_lock_seen", (seen > 0), 1);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
